// File: rtl/layer_scheduler.sv
// Time-multiplexed sequencer for one fully-connected layer. One shared MAC serves
// every output neuron, and the block keeps a running signed argmax over the neuron sums.
module layer_scheduler #(
    parameter int NUM_IN  = 785,
    parameter int NUM_OUT = 10,
    parameter int ACC_W   = 26,
    parameter int ADDR_W  = 10,
    parameter int IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Input_Valid,
    output logic                     busy,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [IDX_W-1:0]         wgt_sel,
    output logic                     mac_clr,
    output logic                     mac_en,
    input  logic                     acc_valid,
    input  logic signed [ACC_W-1:0]  acc_result,
    output logic [IDX_W-1:0]         Out_class,
    output logic signed [ACC_W-1:0]  Out_score,
    output logic                     Output_Valid
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        COMPARE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_E = ADDR_W'(NUM_IN - 1);
    localparam logic [IDX_W-1:0]  LAST_N = IDX_W'(NUM_OUT - 1);

    state_t                   state;
    logic [IDX_W-1:0]         n;
    logic [IDX_W-1:0]         best_class;
    logic [IDX_W-1:0]         next_class;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [ACC_W-1:0]  best_score;
    logic signed [ACC_W-1:0]  next_score;
    logic                     take;

    // Strict signed compare: on ties the earlier (lower) index keeps the lead.
    always_comb begin
        take       = (n == '0) || (sum_q > best_score);
        next_class = take ? n : best_class;
        next_score = take ? sum_q : best_score;
    end

    // rd_addr doubles as the element counter; it is zeroed whenever mac_en drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            n            <= '0;
            sum_q        <= '0;
            best_class   <= '0;
            best_score   <= '0;
            busy         <= 1'b0;
            rd_addr      <= '0;
            wgt_sel      <= '0;
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            Out_class    <= '0;
            Out_score    <= '0;
            Output_Valid <= 1'b0;
        end else begin
            mac_clr      <= 1'b0;
            Output_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Input_Valid) begin
                        state   <= CLEAR;
                        n       <= '0;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                        wgt_sel <= '0;
                    end
                end
                CLEAR: begin
                    state   <= FEED;
                    mac_en  <= 1'b1;
                    rd_addr <= '0;
                    wgt_sel <= n;
                end
                FEED: begin
                    if (rd_addr == LAST_E) begin
                        state   <= DRAIN;
                        mac_en  <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (acc_valid) begin
                        sum_q <= acc_result;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    best_class <= next_class;
                    best_score <= next_score;
                    // Result registers load here so they are already valid in the DONE cycle.
                    if (n == LAST_N) begin
                        state        <= DONE;
                        wgt_sel      <= '0;
                        Out_class    <= next_class;
                        Out_score    <= next_score;
                        Output_Valid <= 1'b1;
                    end else begin
                        state   <= CLEAR;
                        n       <= n + IDX_W'(1);
                        wgt_sel <= n + IDX_W'(1);
                        mac_clr <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: a small instance (4x3) under directed and random
// sums, and a default-size instance for full-length latency and beat counts.
module tb_layer_scheduler;

    localparam int SI = 4, SO = 3, BI = 785, BO = 10, AW = 10, IW = 4, ACCW = 26;
    typedef logic signed [ACCW-1:0] acc_t;
    typedef struct { int cls; acc_t score; longint t_done; } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    int     checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- small instance ----------------
    logic iv_s = 1'b0, av_s = 1'b0;
    acc_t ar_s = '0;
    logic busy_s, clr_s, en_s, ov_s;
    logic [AW-1:0] addr_s;
    logic [IW-1:0] sel_s, cls_s;
    acc_t score_s;

    layer_scheduler #(.NUM_IN(SI), .NUM_OUT(SO), .ACC_W(ACCW), .ADDR_W(AW), .IDX_W(IW)) dut_s (
        .clk(clk), .rst(rst_n), .Input_Valid(iv_s), .busy(busy_s), .rd_addr(addr_s),
        .wgt_sel(sel_s), .mac_clr(clr_s), .mac_en(en_s), .acc_valid(av_s), .acc_result(ar_s),
        .Out_class(cls_s), .Out_score(score_s), .Output_Valid(ov_s));

    acc_t sums_s[SO];
    int   d_s = 3, drain_s = 0;
    bit   stray = 1'b0;
    logic en_prev_s = 1'b0;

    // MAC stand-in: strobe the neuron's sum D cycles into the drain window.
    always @(negedge clk) begin
        av_s = 1'b0;
        ar_s = acc_t'($urandom);
        if (!rst_n) drain_s = 0;
        else if (en_prev_s && !en_s) drain_s = 1;
        else if (drain_s > 0) drain_s++;
        if (drain_s == d_s) begin
            av_s = 1'b1;
            ar_s = sums_s[sel_s];
            drain_s = 0;
        end else if (stray && en_s && $urandom_range(0, 3) == 0) begin
            av_s = 1'b1;
        end
        en_prev_s = rst_n ? en_s : 1'b0;
    end

    exp_t q_s[$];
    int   done_s = 0, nidx = 0, eidx = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (busy_s && !busy_prev) begin nidx = 0; eidx = 0; end
            if (clr_s) begin check("clr_sel", sel_s, nidx); nidx++; eidx = 0; end
            if (en_s) begin
                check("feed_addr", addr_s, eidx);
                check("feed_sel", sel_s, nidx - 1);
                eidx++;
            end else begin
                check("addr_zero", addr_s, 0);
            end
            if (ov_s) begin
                if (q_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ov: Output_Valid with class %0d, expected no result", cls_s);
                end else begin
                    x = q_s.pop_front();
                    check("out_class", cls_s, x.cls);
                    check("out_score", score_s, x.score);
                    check("done_time", cyc + 1, x.t_done);
                    check("busy_at_done", busy_s, 1);
                end
                done_s++;
            end
            busy_prev = busy_s;
        end else begin
            busy_prev = 1'b0;
        end
    end

    task automatic run_small(input acc_t a, input acc_t b, input acc_t c, input int d, input bit str);
        exp_t x;
        int best, start_done;
        sums_s[0] = a; sums_s[1] = b; sums_s[2] = c; d_s = d;
        best = 0;
        for (int i = 1; i < SO; i++) if (sums_s[i] > sums_s[best]) best = i;
        @(negedge clk);
        iv_s = 1'b1;
        x.cls = best; x.score = sums_s[best];
        x.t_done = cyc + 1 + SO * (SI + d + 2) + 1;
        q_s.push_back(x);
        start_done = done_s;
        @(negedge clk);
        iv_s = 1'b0; stray = str;
        for (int k = 0; k < 500 && done_s == start_done; k++) begin
            @(negedge clk);
            if (str) iv_s = busy_s && ($urandom_range(0, 2) == 0);
        end
        iv_s = 1'b0; stray = 1'b0;
        if (done_s == start_done) begin
            checks++; errors++;
            $display("FAIL small_timeout: no Output_Valid, expected one within 500 cycles");
            q_s.delete();
        end
        @(negedge clk); @(negedge clk);
        check("hold_class", cls_s, best);
        check("hold_score", score_s, sums_s[best]);
        check("ov_low_after", ov_s, 0);
        check("busy_low_after", busy_s, 0);
    endtask

    // ---------------- default-size instance ----------------
    logic iv_b = 1'b0, av_b = 1'b0;
    acc_t ar_b = '0;
    logic busy_b, clr_b, en_b, ov_b;
    logic [AW-1:0] addr_b;
    logic [IW-1:0] sel_b, cls_b;
    acc_t score_b;

    layer_scheduler #(.NUM_IN(BI), .NUM_OUT(BO), .ACC_W(ACCW), .ADDR_W(AW), .IDX_W(IW)) dut_b (
        .clk(clk), .rst(rst_n), .Input_Valid(iv_b), .busy(busy_b), .rd_addr(addr_b),
        .wgt_sel(sel_b), .mac_clr(clr_b), .mac_en(en_b), .acc_valid(av_b), .acc_result(ar_b),
        .Out_class(cls_b), .Out_score(score_b), .Output_Valid(ov_b));

    acc_t sums_b[BO];
    int   drain_b = 0, en_cnt = 0, clr_cnt = 0, eb = 0, done_b = 0;
    logic en_prev_b = 1'b0;
    exp_t q_b[$];

    always @(negedge clk) begin
        exp_t x;
        av_b = 1'b0;
        ar_b = '0;
        if (!rst_n) drain_b = 0;
        else if (en_prev_b && !en_b) drain_b = 1;
        else if (drain_b > 0) drain_b++;
        if (drain_b == 8) begin
            av_b = 1'b1;
            ar_b = sums_b[sel_b];
            drain_b = 0;
        end
        en_prev_b = rst_n ? en_b : 1'b0;
        if (rst_n) begin
            if (clr_b) begin check("big_clr_sel", sel_b, clr_cnt); clr_cnt++; eb = 0; end
            if (en_b) begin check("big_feed_addr", addr_b, eb); eb++; en_cnt++; end
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL big_unexpected_ov: Output_Valid with class %0d, expected no result", cls_b);
                end else begin
                    x = q_b.pop_front();
                    check("big_class", cls_b, x.cls);
                    check("big_score", score_b, x.score);
                    check("big_latency", cyc + 1, x.t_done);
                    check("big_mac_en_cycles", en_cnt, BI * BO);
                    check("big_mac_clr_pulses", clr_cnt, BO);
                    check("big_busy", busy_b, 1);
                end
                done_b++;
            end
        end
    end

    task automatic run_big();
        exp_t x;
        int best;
        for (int i = 0; i < BO; i++) sums_b[i] = acc_t'($urandom);
        sums_b[7] = sums_b[3];
        best = 0;
        for (int i = 1; i < BO; i++) if (sums_b[i] > sums_b[best]) best = i;
        @(negedge clk);
        en_cnt = 0; clr_cnt = 0;
        iv_b = 1'b1;
        x.cls = best; x.score = sums_b[best];
        x.t_done = cyc + 1 + 7951;
        q_b.push_back(x);
        @(negedge clk);
        iv_b = 1'b0;
        for (int k = 0; k < 9000 && done_b == 0; k++) @(negedge clk);
        if (done_b == 0) begin
            checks++; errors++;
            $display("FAIL big_timeout: no Output_Valid, expected one within 9000 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a, b, c;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_s, 0);
        check("rst_addr", addr_s, 0);
        check("rst_sel", sel_s, 0);
        check("rst_clr", clr_s, 0);
        check("rst_en", en_s, 0);
        check("rst_class", cls_s, 0);
        check("rst_score", score_s, 0);
        check("rst_ov", ov_s, 0);
        check("rst_big_busy", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_small(acc_t'(5), acc_t'(-2), acc_t'(9), 3, 1'b0);
        run_small(acc_t'(7), acc_t'(7), acc_t'(-1), 3, 1'b0);
        run_small(acc_t'(-100), acc_t'(-3), acc_t'(-50), 3, 1'b0);
        check("neg3_bits", {38'd0, score_s}, 64'h3FFFFFD);
        run_small(acc_t'(5), acc_t'(-2), acc_t'(9), 3, 1'b1);

        // Abort a run mid-FEED of neuron 1, between clock edges.
        @(negedge clk);
        iv_s = 1'b1;
        @(negedge clk);
        iv_s = 1'b0;
        for (int k = 0; k < 100 && !(en_s && sel_s == 1); k++) @(negedge clk);
        check("reached_feed1", en_s && sel_s == 1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_s, 0);
        check("abort_addr", addr_s, 0);
        check("abort_sel", sel_s, 0);
        check("abort_clr", clr_s, 0);
        check("abort_en", en_s, 0);
        check("abort_class", cls_s, 0);
        check("abort_score", score_s, 0);
        check("abort_ov", ov_s, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        run_small(acc_t'(5), acc_t'(-2), acc_t'(9), 3, 1'b0);

        for (int r = 0; r < 10; r++) begin
            if (r % 2 == 0) begin
                a = acc_t'($urandom); b = acc_t'($urandom); c = acc_t'($urandom);
            end else begin
                a = acc_t'($urandom_range(0, 6)) - acc_t'(3);
                b = acc_t'($urandom_range(0, 6)) - acc_t'(3);
                c = acc_t'($urandom_range(0, 6)) - acc_t'(3);
            end
            run_small(a, b, c, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        run_big();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Sequencing controller for one fully-connected layer of the digit classifier. It time-multiplexes a single shared multiply-accumulate datapath across all NUM_OUT output neurons: it clears the accumulator, streams element addresses for one neuron, and waits for the accumulated sum. It then keeps a running signed argmax over the neurons. It sits between the top-level image-load logic and the MAC/weight-ROM/pixel-buffer datapath, and replaces ten parallel neuron instances with one.

## Interface
Parameters:
- NUM_IN, 785, elements per neuron (784 pixels + bias term)
- NUM_OUT, 10, output neurons (classes)
- ACC_W, 26, signed accumulator/result width
- ADDR_W, 10, element address width; must satisfy 2^ADDR_W >= NUM_IN
- IDX_W, 4, neuron index width; must satisfy 2^IDX_W >= NUM_OUT

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- Input_Valid  in  1  start pulse; image and weights ready
- busy  out  1  high from start acceptance through the Output_Valid cycle
- rd_addr  out  ADDR_W  element index to pixel buffer and weight ROM
- wgt_sel  out  IDX_W  current neuron index (weight ROM bank select)
- mac_clr  out  1  clear accumulator (one cycle)
- mac_en  out  1  rd_addr is valid this cycle; MAC accumulates it
- acc_valid  in  1  MAC final-sum strobe
- acc_result  in  ACC_W  MAC final sum, two's complement, valid with acc_valid
- Out_class  out  IDX_W  winning neuron index
- Out_score  out  ACC_W  winning neuron's sum
- Output_Valid  out  1  one-cycle result strobe

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, COMPARE, DONE.
- IDLE: Input_Valid=1 → CLEAR, with neuron index n=0 and best score/class invalidated. busy rises.
- CLEAR: mac_clr=1 for exactly one cycle → FEED, with element counter e=0.
- FEED: mac_en=1, rd_addr=e, wgt_sel=n. e increments every cycle. At e=NUM_IN-1 → DRAIN.
- DRAIN: mac_en=0. Wait indefinitely for acc_valid=1. On acc_valid, latch acc_result → COMPARE.
- COMPARE: if n==0 or latched sum > best score (signed, strict), update best score and best class to n.
  - If n==NUM_OUT-1 → DONE; else n+1 → CLEAR.
- DONE: Output_Valid=1 for one cycle. Out_class/Out_score load the best values → IDLE.
- Out_class/Out_score hold their value until the next DONE.
- Ties: strict compare, so the lowest index wins.
- Input_Valid outside IDLE is ignored. It is not queued.
- acc_valid outside DRAIN is ignored.
- No saturation is applied. Comparison is full-width signed on ACC_W bits.
- rd_addr and wgt_sel are 0 whenever mac_en=0, except that wgt_sel holds n during CLEAR/DRAIN/COMPARE.
- Reset (rst=0) at any time:
  - Returns the block to IDLE. Any run in progress is aborted with no Output_Valid.
  - All outputs go to 0: busy, rd_addr, wgt_sel, mac_clr, mac_en, Out_class, Out_score, Output_Valid.

## Timing
- Input_Valid sampled at edge T0. The CLEAR cycle is T0+1. FEED cycles are T0+2 .. T0+NUM_IN+1, with rd_addr 0..NUM_IN-1 in order, no gaps.
- DRAIN starts at T0+NUM_IN+2. If acc_valid arrives D cycles into DRAIN (D≥1, counting the strobe cycle), COMPARE is the next cycle.
- Per-neuron period is NUM_IN + D + 2 cycles. The next CLEAR immediately follows COMPARE.
- Output_Valid occurs the cycle after the last COMPARE. Total latency from T0 is NUM_OUT*(NUM_IN+D+2)+1 cycles.
- Example, defaults with D=8: 7951 cycles.
- Back-to-back runs: Input_Valid is accepted in the first IDLE cycle after DONE.
- All outputs are registered. Outputs do not depend combinationally on inputs.

## Test plan
- Sizes NUM_IN=4, NUM_OUT=3; MAC model returning acc_valid at D=3; sums {5,-2,9}.
  - Required: Out_class=2, Out_score=9, Output_Valid for one cycle at T0+28.
  - Required: each FEED burst has rd_addr 0,1,2,3 and wgt_sel 0,1,2.
- Sums {7,7,-1} → Out_class=0, Out_score=7 (tie keeps lower index).
- Sums {-100,-3,-50} → Out_class=1, Out_score=-3. This checks the signed compare; 26-bit -3 = 0x3FFFFFD.
- Input_Valid re-pulsed during FEED and DRAIN.
  - Required: no restart, identical output and timing to the first scenario.
  - Required: a stray acc_valid during FEED has no effect.
- rst=0 asserted mid-FEED of neuron 1.
  - Required: all outputs 0 immediately, with no clock edge needed.
  - Required: no Output_Valid.
  - Required: after release, a new Input_Valid completes normally.
- Default parameters with D=8.
  - Required: Output_Valid at T0+7951.
  - Required: exactly 7850 mac_en cycles and 10 mac_clr pulses.
